dmem_arbiter: RTL and testbench

Two-master arbiter in front of the single-port data RAM (`sp_ram`). Master 0 is the core load/store unit. Master 1 is a secondary requester: the debug/preload port or a future DMA. Each cycle the block grants at most one request, drives the RAM, and routes the one-cycle-late read data and response back to the winner. The loser is stalled by holding its grant low, which is the mechanism behind the core's store-stall behaviour.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_sel.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   owner_e          : which master the one-cycle-late response belongs to
//   DMEM_NUM_MASTERS : number of requesters in front of the RAM
//   DMEM_WAIT_W      : width of the master-1 starvation counter
package dmem_arb_pkg;

  localparam int DMEM_NUM_MASTERS = 2;
  localparam int DMEM_WAIT_W      = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_sel.sv
// Arbitration decision for the data-RAM arbiter (purely combinational).
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority
// (M0 wins) with a starvation guard that forces M1 through after MAX_WAIT
// consecutive denied cycles.
// Ports:
//   req_i    : request vector, bit x = master x
//   rr_i     : round-robin pointer (0 = M0 preferred on contention)
//   wait_i   : consecutive denied cycles seen by master 1
//   gnt_o    : one-hot (or zero) grant vector
//   rr_d_o   : next round-robin pointer
//   wait_d_o : next starvation counter value
module dmem_arb_sel
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic [DMEM_NUM_MASTERS-1:0] req_i,
  input  logic                        rr_i,
  input  logic [DMEM_WAIT_W-1:0]      wait_i,
  output logic [DMEM_NUM_MASTERS-1:0] gnt_o,
  output logic                        rr_d_o,
  output logic [DMEM_WAIT_W-1:0]      wait_d_o
);

`ifdef DMEM_ARB_RR_EN
  // Counter and its limit have no role in round-robin mode.
  logic                   unused_wait;
  logic [DMEM_WAIT_W-1:0] unused_limit;
  assign unused_wait  = ^wait_i;
  assign unused_limit = DMEM_WAIT_W'(MAX_WAIT);

  always_comb begin
    gnt_o    = '0;
    rr_d_o   = rr_i;
    wait_d_o = '0;
    if (req_i == 2'b11) begin
      gnt_o  = rr_i ? 2'b10 : 2'b01;
      // Pointer moves to the loser so it wins the next contended cycle.
      rr_d_o = ~rr_i;
    end else begin
      gnt_o = req_i;
    end
  end
`else
  localparam logic [DMEM_WAIT_W-1:0] WaitLimit = DMEM_WAIT_W'(MAX_WAIT);

  logic starved;
  assign starved = (wait_i >= WaitLimit);

  always_comb begin
    gnt_o    = '0;
    rr_d_o   = rr_i;
    wait_d_o = '0;
    if (req_i[1] && (!req_i[0] || starved)) begin
      gnt_o = 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end
    // Count only while M1 is asking and losing; any M1 grant or a dropped
    // request restarts the count.
    if (req_i[1] && !gnt_o[1]) begin
      wait_d_o = wait_i + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data RAM.
// Master 0 is the core load/store unit, master 1 the debug/preload/DMA port.
// One request is granted per cycle (combinationally); the loser sees gnt low
// and must hold its request. The response (rvalid + rdata) is routed to the
// master that owned the RAM in the previous cycle.
// Build option: DMEM_ARB_RR_EN (defined = round-robin, undefined = fixed
// priority with starvation guard on master 1).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   mX_req/we/be/addr/wdata  : master X request (byte address)
//   mX_gnt                   : master X accepted this cycle
//   mX_rvalid/rdata          : master X response, one cycle after grant
//   mem_req/we/be/addr/wdata : RAM request (word address)
//   mem_rdata                : RAM read data, one cycle after mem_req
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [31:0]         m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [31:0]         m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic [DMEM_NUM_MASTERS-1:0] req_v;
  logic [DMEM_NUM_MASTERS-1:0] gnt;
  logic                        rr_q, rr_d;
  logic [DMEM_WAIT_W-1:0]      wait_q, wait_d;
  owner_e                      owner_q, owner_d;

  // Byte-offset bits and bits above the RAM size are don't-care (aliasing).
  logic unused_addr;
  assign unused_addr = ^{m0_addr[1:0], m0_addr[31:ADDR_W+2],
                         m1_addr[1:0], m1_addr[31:ADDR_W+2]};

  // Grants are suppressed for as long as reset is held.
  assign req_v = rst ? '0 : {m1_req, m0_req};

  dmem_arb_sel #(
    .MAX_WAIT (MAX_WAIT)
  ) u_sel (
    .req_i    (req_v),
    .rr_i     (rr_q),
    .wait_i   (wait_q),
    .gnt_o    (gnt),
    .rr_d_o   (rr_d),
    .wait_d_o (wait_d)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign mem_req = |gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (gnt[1]) begin
      mem_we    = m1_we;
      mem_be    = m1_be;
      mem_addr  = m1_addr[ADDR_W+1:2];
      mem_wdata = m1_wdata;
      owner_d   = OWN_M1;
    end else if (gnt[0]) begin
      mem_we    = m0_we;
      mem_be    = m0_be;
      mem_addr  = m0_addr[ADDR_W+1:2];
      mem_wdata = m0_wdata;
      owner_d   = OWN_M0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      rr_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
    end
  end

  assign m0_rvalid = (owner_q == OWN_M0);
  assign m1_rvalid = (owner_q == OWN_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [BW-1:0] m0_be, m1_be;
  logic [31:0]   m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Single-port RAM stand-in: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_be);
    end
  end

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic set_m0(input logic rq, input logic we, input logic [BW-1:0] be,
                        input logic [31:0] a, input logic [DW-1:0] wd);
    m0_req = rq; m0_we = we; m0_be = be; m0_addr = a; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic rq, input logic we, input logic [BW-1:0] be,
                        input logic [31:0] a, input logic [DW-1:0] wd);
    m1_req = rq; m1_we = we; m1_be = be; m1_addr = a; m1_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [DW*4+BW+AW+8-1:0] all_out;
    set_m0(1, 0, '0, 32'h0, '0);
    set_m1(1, 0, '0, 32'h4, '0);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({m1_gnt, m0_gnt, mem_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_gnt_forced: got %b expected 000", {m1_gnt, m0_gnt, mem_req});
      end
      step();
    end
    idle();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      all_out = {m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                 mem_req, mem_we, mem_be, mem_addr, mem_wdata, 2'b00, 32'h0};
      n_checks++;
      if (all_out !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs cycle %0d: got %h expected 0", i, all_out);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    set_m0(1, 0, '0, 32'h0, '0);
    @(negedge clk);
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_gnt: got %b expected 1", m0_gnt);
    end
    step();
    idle();
    n_checks++;
    if (m0_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_owner: got %b expected 1", m0_rvalid);
    end
    rst = 1;
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async_drop: got %b expected 0", m0_rvalid);
    end
    step();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_after: got %b expected 00", {m1_rvalid, m0_rvalid});
    end
    step();
  endtask

  task automatic test_read();
    for (int i = 0; i < 4; i++) begin
      ram[i]    = 32'h11111111 * (i + 1);
      shadow[i] = 32'h11111111 * (i + 1);
    end
    set_m0(1, 0, '0, 32'h8, '0);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, m0_gnt, mem_req, mem_we, mem_addr} !== {4'b0110, 12'h2}) begin
      n_fail++;
      $display("FAIL read_issue: got %b%b%b%b %h expected 0110 002",
               m1_gnt, m0_gnt, mem_req, mem_we, mem_addr);
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({m1_rvalid, m0_rvalid, m0_rdata} !== {2'b01, 32'h33333333}) begin
      n_fail++;
      $display("FAIL read_resp: got %b%b %h expected 01 33333333", m1_rvalid, m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_write_be();
    set_m1(1, 1, 4'b0011, 32'h4, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, m0_gnt, mem_we, mem_be, mem_addr, mem_wdata} !==
        {3'b101, 4'b0011, 12'h1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wr_issue: got %b%b%b %b %h %h expected 101 0011 001 deadbeef",
               m1_gnt, m0_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    end
    shadow[1] = merge(shadow[1], 32'hDEADBEEF, 4'b0011);
    step();
    idle();
    set_m0(1, 0, '0, 32'h4, '0);
    @(negedge clk);
    n_checks++;
    if ({m1_rvalid, m0_rvalid, m0_gnt} !== 3'b101) begin
      n_fail++;
      $display("FAIL wr_resp: got %b%b%b expected 101", m1_rvalid, m0_rvalid, m0_gnt);
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h2222BEEF}) begin
      n_fail++;
      $display("FAIL wr_readback: got %b %h expected 1 2222beef", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] eg, prev_g;
    int         streak, max_streak;
    do_reset();
    set_m0(1, 0, '0, 32'h0, '0);
    set_m1(1, 0, '0, 32'hC, '0);
    prev_g = 2'b00; streak = 0; max_streak = 0;
    for (int i = 0; i < 20; i++) begin
`ifdef DMEM_ARB_RR_EN
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      eg = (i % (MW + 1) == MW) ? 2'b10 : 2'b01;
`endif
      @(negedge clk);
      n_checks++;
      if ({m1_gnt, m0_gnt} !== eg) begin
        n_fail++;
        $display("FAIL cont_gnt cycle %0d: got %b expected %b", i, {m1_gnt, m0_gnt}, eg);
      end
      n_checks++;
      if ({m1_rvalid, m0_rvalid} !== prev_g) begin
        n_fail++;
        $display("FAIL cont_rvalid cycle %0d: got %b expected %b", i, {m1_rvalid, m0_rvalid}, prev_g);
      end
      if (prev_g == 2'b01) begin
        n_checks++;
        if (m0_rdata !== shadow[0]) begin
          n_fail++; $display("FAIL cont_m0_rdata cycle %0d: got %h expected %h", i, m0_rdata, shadow[0]);
        end
      end else if (prev_g == 2'b10) begin
        n_checks++;
        if (m1_rdata !== shadow[3]) begin
          n_fail++; $display("FAIL cont_m1_rdata cycle %0d: got %h expected %h", i, m1_rdata, shadow[3]);
        end
      end
      streak = m1_gnt ? 0 : streak + 1;
      if (streak > max_streak) max_streak = streak;
      prev_g = eg;
      step();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({m1_rvalid, m0_rvalid} !== prev_g) begin
      n_fail++; $display("FAIL cont_last_rvalid: got %b expected %b", {m1_rvalid, m0_rvalid}, prev_g);
    end
    n_checks++;
    if (max_streak > MW) begin
      n_fail++; $display("FAIL cont_starve: m1 denied %0d cycles, limit %0d", max_streak, MW);
    end
    step();
  endtask

  task automatic test_store_stall();
`ifdef DMEM_ARB_RR_EN
    int d = 1;
`else
    int d = MW;
`endif
    do_reset();
    set_m0(1, 0, '0, 32'h0, '0);
    set_m1(1, 0, '0, 32'h8, '0);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      n_checks++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
        n_fail++; $display("FAIL stall_pre cycle %0d: got %b expected 01", i, {m1_gnt, m0_gnt});
      end
      step();
    end
    set_m0(1, 1, 4'hF, 32'hC, 32'hCAFEF00D);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL stall_blocked: got %b expected 10", {m1_gnt, m0_gnt});
    end
    step();
    set_m1(0, 0, '0, 32'h0, '0);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, m0_gnt, mem_we, mem_addr, mem_wdata} !== {3'b011, 12'h3, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL stall_accept: got %b%b%b %h %h expected 011 003 cafef00d",
               m1_gnt, m0_gnt, mem_we, mem_addr, mem_wdata);
    end
    shadow[3] = 32'hCAFEF00D;
    step();
    set_m0(1, 0, '0, 32'hC, '0);
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL stall_readback: got %b %h expected 1 cafef00d", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_random();
    logic [1:0]    pend, eg, prev_g;
    logic [1:0]    we_a;
    logic [BW-1:0] be_a [2];
    logic [31:0]   ad_a [2];
    logic [DW-1:0] wd_a [2];
    logic          prev_w;
    logic [DW-1:0] prev_d, exp_rd;
    logic [AW-1:0] idx;
    int            denied, w;
    bit            pref;
    do_reset();
    pend = '0; prev_g = '0; prev_w = 0; prev_d = '0;
    denied = 0; pref = 0; we_a = '0;
    for (int m = 0; m < 2; m++) begin be_a[m] = '0; ad_a[m] = '0; wd_a[m] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 9) < 7) begin
          pend[m] = 1'b1;
          we_a[m] = 1'($urandom_range(0, 1));
          be_a[m] = BW'($urandom);
          ad_a[m] = $urandom;
          wd_a[m] = $urandom;
        end
      end
      set_m0(pend[0], we_a[0], be_a[0], ad_a[0], wd_a[0]);
      set_m1(pend[1], we_a[1], be_a[1], ad_a[1], wd_a[1]);
      // Reference: who should win this cycle.
      eg = pend;
      if (pend == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
        w = int'(pref);
        pref = ~pref;
`else
        w = (denied == MW) ? 1 : 0;
`endif
        eg = 2'b00;
        eg[w] = 1'b1;
      end
      if (pend[1] && !eg[1]) denied++; else denied = 0;
      w = eg[1] ? 1 : 0;
      idx = ad_a[w][AW+1:2];
      @(negedge clk);
      n_checks++;
      if ({m1_gnt, m0_gnt, mem_req} !== {eg, |eg}) begin
        n_fail++;
        $display("FAIL rnd_gnt cycle %0d: got %b expected %b", c, {m1_gnt, m0_gnt, mem_req}, {eg, |eg});
      end
      n_checks++;
      if (eg == 2'b00) begin
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
          n_fail++; $display("FAIL rnd_mem_idle cycle %0d: got %b %h %h", c, mem_we, mem_addr, mem_wdata);
        end
      end else if (we_a[w]) begin
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, be_a[w], idx, wd_a[w]}) begin
          n_fail++;
          $display("FAIL rnd_mem_wr cycle %0d: got %b %b %h %h expected 1 %b %h %h",
                   c, mem_we, mem_be, mem_addr, mem_wdata, be_a[w], idx, wd_a[w]);
        end
      end else begin
        if ({mem_we, mem_addr} !== {1'b0, idx}) begin
          n_fail++;
          $display("FAIL rnd_mem_rd cycle %0d: got %b %h expected 0 %h", c, mem_we, mem_addr, idx);
        end
      end
      n_checks++;
      if ({m1_rvalid, m0_rvalid} !== prev_g) begin
        n_fail++;
        $display("FAIL rnd_rvalid cycle %0d: got %b expected %b", c, {m1_rvalid, m0_rvalid}, prev_g);
      end
      exp_rd = (prev_g[0] && !prev_w) ? prev_d : '0;
      if (!(prev_g[0] && prev_w)) begin
        n_checks++;
        if (m0_rdata !== exp_rd) begin
          n_fail++; $display("FAIL rnd_m0_rdata cycle %0d: got %h expected %h", c, m0_rdata, exp_rd);
        end
      end
      exp_rd = (prev_g[1] && !prev_w) ? prev_d : '0;
      if (!(prev_g[1] && prev_w)) begin
        n_checks++;
        if (m1_rdata !== exp_rd) begin
          n_fail++; $display("FAIL rnd_m1_rdata cycle %0d: got %h expected %h", c, m1_rdata, exp_rd);
        end
      end
      if (eg != 2'b00) begin
        prev_w = we_a[w];
        if (we_a[w]) shadow[idx] = merge(shadow[idx], wd_a[w], be_a[w]);
        else         prev_d = shadow[idx];
        pend[w] = 1'b0;
      end
      prev_g = eg;
      step();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({m1_rvalid, m0_rvalid} !== prev_g) begin
      n_fail++; $display("FAIL rnd_last_rvalid: got %b expected %b", {m1_rvalid, m0_rvalid}, prev_g);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    idle();
    rst = 1;
    test_reset();
    test_reset_mid();
    test_read();
    test_write_be();
    test_contention();
    test_store_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
